// File: rtl/rooth_flow_pkg.sv
// rooth_flow_pkg: per-stage flow codes, controller states and decision selectors shared by the rooth flow logic
package rooth_flow_pkg;
   localparam int FLOW_WIDTH = 2;
   localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'b00;
   localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'b01;
   localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'b10;
   typedef enum logic [1:0] {IDLE, DRAIN, RESUME} fsm_e;
   typedef enum logic [2:0] {SEL_IRQ, SEL_HOLD, SEL_PEND, SEL_DRAIN, SEL_RESUME, SEL_REDIR, SEL_FENCE, SEL_RUN} sel_e;
   function automatic logic [FLOW_WIDTH-1:0] refresh_upto(input int s, input int k);
      return (s >= 1 && s <= k) ? FLOW_REFRESH : FLOW_WORK;
   endfunction
endpackage

// File: rtl/flow_hold_merge.sv
// flow_hold_merge: picks the deepest requested hold stage and expands it into a per-stage flow pattern
module flow_hold_merge
   import rooth_flow_pkg::*;
#(
   parameter int STAGES    = 5,
   parameter int HOLD_SRCS = 4,
   parameter int SIDX_W    = $clog2(STAGES)
) (
   input  logic [HOLD_SRCS-1:0]         hold_req,
   input  logic [HOLD_SRCS*SIDX_W-1:0]  hold_stage,
   output logic                         any_hold,
   output logic [SIDX_W-1:0]            hold_max,
   output logic [STAGES*FLOW_WIDTH-1:0] hold_flow
);
   assign any_hold = |hold_req;
   always_comb begin
      hold_max = '0;
      for (int i = 0; i < HOLD_SRCS; i++)
         if (hold_req[i] && hold_stage[i*SIDX_W +: SIDX_W] > hold_max) hold_max = hold_stage[i*SIDX_W +: SIDX_W];
      for (int s = 0; s < STAGES; s++)
         hold_flow[s*FLOW_WIDTH +: FLOW_WIDTH] = s <= int'(hold_max) ? FLOW_STOP :
                                                 s == int'(hold_max) + 1 ? FLOW_REFRESH : FLOW_WORK;
   end
endmodule

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: per-stage stop/refresh/work control and PC steering with pending redirect, fence drain and stall watchdog
module pipe_flow_ctrl
   import rooth_flow_pkg::*;
#(
   parameter  int STAGES      = 5,
   parameter  int HOLD_SRCS   = 4,
   parameter  int REDIR_STAGE = 2,
   parameter  int CPU_WIDTH   = 32,
   parameter  int WDOG_W      = 8,
   localparam int SIDX_W      = $clog2(STAGES)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [HOLD_SRCS-1:0]         hold_req_i,
   input  logic [HOLD_SRCS*SIDX_W-1:0]  hold_stage_i,
   input  logic                         irq_req_i,
   input  logic [CPU_WIDTH-1:0]         irq_addr_i,
   input  logic                         redirect_req_i,
   input  logic [CPU_WIDTH-1:0]         redirect_pc_i,
   input  logic [SIDX_W-1:0]            redirect_kill_i,
   input  logic                         fence_req_i,
   input  logic [CPU_WIDTH-1:0]         fence_pc_i,
   input  logic                         timeout_clr_i,
   output logic [STAGES*FLOW_WIDTH-1:0] flow_o,
   output logic [CPU_WIDTH-1:0]         next_pc_o,
   output logic                         next_pc_vld_o,
   output logic                         next_pc_four_o,
   output logic                         stall_timeout_o,
   output logic                         busy_o
);
   localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
   localparam logic [SIDX_W-1:0] DRAIN_LEN = SIDX_W'(STAGES - 2);
   fsm_e state, state_nxt;
   sel_e sel;
   logic [SIDX_W-1:0] cnt, cnt_nxt, pend_kill, pend_kill_nxt, hold_max;
   logic [CPU_WIDTH-1:0] pend_pc, pend_pc_nxt, fence_pc, fence_pc_nxt;
   logic [WDOG_W-1:0] wdog, wdog_nxt;
   logic [STAGES*FLOW_WIDTH-1:0] hold_flow;
   logic pend_vld, pend_vld_nxt, any_hold, timeout, stop0;
   int kill;
   flow_hold_merge #(.STAGES(STAGES), .HOLD_SRCS(HOLD_SRCS), .SIDX_W(SIDX_W)) u_merge (
      .hold_req(hold_req_i), .hold_stage(hold_stage_i), .any_hold(any_hold), .hold_max(hold_max), .hold_flow(hold_flow)
   );
   // Fence is only reachable from IDLE because DRAIN/RESUME take precedence over it.
   assign sel = irq_req_i ? SEL_IRQ : any_hold ? SEL_HOLD : pend_vld ? SEL_PEND :
                state == DRAIN ? SEL_DRAIN : state == RESUME ? SEL_RESUME :
                redirect_req_i ? SEL_REDIR : fence_req_i ? SEL_FENCE : SEL_RUN;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         pend_vld  <= 1'b0;
         pend_pc   <= '0;
         pend_kill <= '0;
         fence_pc  <= '0;
         wdog      <= '0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pend_vld  <= pend_vld_nxt;
         pend_pc   <= pend_pc_nxt;
         pend_kill <= pend_kill_nxt;
         fence_pc  <= fence_pc_nxt;
         wdog      <= wdog_nxt;
         timeout   <= (wdog_nxt == WDOG_MAX) | (timeout & ~timeout_clr_i);
      end
   end
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pend_vld_nxt  = pend_vld;
      pend_pc_nxt   = pend_pc;
      pend_kill_nxt = pend_kill;
      fence_pc_nxt  = fence_pc;
      case (sel)
         SEL_IRQ: begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            pend_vld_nxt = 1'b0;
         end
         SEL_HOLD:
            if (redirect_req_i && int'(hold_max) < REDIR_STAGE && !pend_vld) begin
               pend_vld_nxt  = 1'b1;
               pend_pc_nxt   = redirect_pc_i;
               pend_kill_nxt = redirect_kill_i;
            end
         SEL_PEND: pend_vld_nxt = 1'b0;
         SEL_DRAIN: begin
            cnt_nxt   = cnt - SIDX_W'(cnt != '0);
            state_nxt = cnt <= SIDX_W'(1) ? RESUME : DRAIN;
         end
         SEL_RESUME: state_nxt = IDLE;
         SEL_FENCE: begin
            state_nxt    = DRAIN;
            cnt_nxt      = DRAIN_LEN;
            fence_pc_nxt = fence_pc_i;
         end
         default: ;
      endcase
      wdog_nxt = !any_hold ? '0 : wdog == WDOG_MAX ? WDOG_MAX : wdog + 1'b1;
   end
   assign stop0 = sel inside {SEL_DRAIN, SEL_FENCE};
   assign kill  = sel == SEL_IRQ ? STAGES - 1 : sel == SEL_PEND ? int'(pend_kill) : sel == SEL_DRAIN ? 1 :
                  sel == SEL_REDIR ? int'(redirect_kill_i) : sel == SEL_FENCE ? REDIR_STAGE : 0;
   always_comb begin
      for (int s = 0; s < STAGES; s++)
         flow_o[s*FLOW_WIDTH +: FLOW_WIDTH] = !rst_n ? FLOW_STOP : sel == SEL_HOLD ? hold_flow[s*FLOW_WIDTH +: FLOW_WIDTH] :
                                              (s == 0 && stop0) ? FLOW_STOP : refresh_upto(s, kill);
      next_pc_vld_o  = rst_n && (sel inside {SEL_IRQ, SEL_PEND, SEL_RESUME, SEL_REDIR});
      next_pc_four_o = rst_n && sel == SEL_RUN;
      next_pc_o      = !rst_n ? '0 : sel == SEL_IRQ ? irq_addr_i : sel == SEL_PEND ? pend_pc :
                       sel == SEL_RESUME ? fence_pc + CPU_WIDTH'(4) : sel == SEL_REDIR ? redirect_pc_i : '0;
   end
   assign stall_timeout_o = timeout;
   assign busy_o          = state != IDLE || pend_vld;
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: directed checks of flow codes, PC steering, fence drain, pending redirect and watchdog
module tb_pipe_flow_ctrl;
   localparam logic [1:0] W = 2'b00, S = 2'b01, R = 2'b10;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [3:0] hold_req;
   logic [11:0] hold_stage;
   logic irq_req, redirect_req, fence_req, timeout_clr;
   logic [31:0] irq_addr, redirect_pc, fence_pc;
   logic [2:0] redirect_kill;
   logic [9:0] flow;
   logic [31:0] next_pc;
   logic vld, four, tmo, busy;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   pipe_flow_ctrl #(.WDOG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .hold_req_i(hold_req), .hold_stage_i(hold_stage),
      .irq_req_i(irq_req), .irq_addr_i(irq_addr), .redirect_req_i(redirect_req),
      .redirect_pc_i(redirect_pc), .redirect_kill_i(redirect_kill), .fence_req_i(fence_req),
      .fence_pc_i(fence_pc), .timeout_clr_i(timeout_clr), .flow_o(flow), .next_pc_o(next_pc),
      .next_pc_vld_o(vld), .next_pc_four_o(four), .stall_timeout_o(tmo), .busy_o(busy)
   );
   function automatic logic [9:0] fl(input logic [1:0] c4, c3, c2, c1, c0);
      return {c4, c3, c2, c1, c0};
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic [9:0] ef, input logic [31:0] epc, input logic ev, input logic e4);
      chk({tag, ".flow"}, 64'(flow), 64'(ef));
      chk({tag, ".pc"}, 64'(next_pc), 64'(epc));
      chk({tag, ".vld"}, 64'(vld), 64'(ev));
      chk({tag, ".four"}, 64'(four), 64'(e4));
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in;
      hold_req = '0; hold_stage = '0; irq_req = 0; irq_addr = '0; redirect_req = 0;
      redirect_pc = '0; redirect_kill = '0; fence_req = 0; fence_pc = '0; timeout_clr = 0;
   endtask
   localparam logic [9:0] ALLW = 10'b0, DRN = {W, W, W, R, S};
   initial begin
      idle_in;
      #12;
      chk_out("reset", fl(S, S, S, S, S), 32'h0, 0, 0);
      chk("reset.tmo", 64'(tmo), 64'd0);
      chk("reset.busy", 64'(busy), 64'd0);
      tick; rst_n = 1; #1;
      chk_out("idle", ALLW, 32'h0, 0, 1);
      // single hold at stage 3
      tick; hold_req = 4'b0001; hold_stage = 12'h003; #1;
      chk_out("hold3", fl(R, S, S, S, S), 32'h0, 0, 0);
      tick; idle_in; #1;
      chk_out("hold3_rel", ALLW, 32'h0, 0, 1);
      // shallow hold latches redirect
      tick; hold_req = 4'b0010; hold_stage = 12'h008; redirect_req = 1; redirect_pc = 32'h100; redirect_kill = 3'd2; #1;
      chk_out("hold1_redir", fl(W, W, R, S, S), 32'h0, 0, 0);
      tick; idle_in; #1;
      chk("pend_busy", 64'(busy), 64'd1);
      chk_out("pend_apply", fl(W, W, R, R, W), 32'h100, 1, 0);
      tick; #1;
      chk("pend_done.busy", 64'(busy), 64'd0);
      chk_out("pend_done", ALLW, 32'h0, 0, 1);
      // deep hold ignores redirect; re-presented one applies live
      tick; hold_req = 4'b0100; hold_stage = 12'h0C0; redirect_req = 1; redirect_pc = 32'h200; redirect_kill = 3'd1; #1;
      chk_out("hold3_redir", fl(R, S, S, S, S), 32'h0, 0, 0);
      tick; hold_req = '0; hold_stage = '0; #1;
      chk("no_latch.busy", 64'(busy), 64'd0);
      chk_out("redir_live", fl(W, W, W, R, W), 32'h200, 1, 0);
      // fence with a 2-cycle hold mid-drain
      tick; idle_in; fence_req = 1; fence_pc = 32'h40; #1;
      chk_out("fence_entry", fl(W, W, R, R, S), 32'h0, 0, 0);
      tick; idle_in; #1;
      chk_out("drain1", DRN, 32'h0, 0, 0);
      chk("drain1.busy", 64'(busy), 64'd1);
      tick; hold_req = 4'b0001; hold_stage = 12'h001; #1;
      chk_out("drain_hold1", fl(W, W, R, S, S), 32'h0, 0, 0);
      tick; #1;
      chk_out("drain_hold2", fl(W, W, R, S, S), 32'h0, 0, 0);
      tick; idle_in; #1;
      chk_out("drain2", DRN, 32'h0, 0, 0);
      tick; #1;
      chk_out("drain3", DRN, 32'h0, 0, 0);
      tick; #1;
      chk_out("resume", ALLW, 32'h44, 1, 0);
      tick; #1;
      chk_out("fence_done", ALLW, 32'h0, 0, 1);
      chk("fence_done.busy", 64'(busy), 64'd0);
      // irq during drain with pending redirect
      tick; fence_req = 1; fence_pc = 32'h60;
      tick; idle_in; hold_req = 4'b0001; hold_stage = 12'h000; redirect_req = 1; redirect_pc = 32'h300; redirect_kill = 3'd3; #1;
      chk_out("drain_hold_redir", fl(W, W, W, R, S), 32'h0, 0, 0);
      tick; idle_in; irq_req = 1; irq_addr = 32'h80; #1;
      chk("irq_pre.busy", 64'(busy), 64'd1);
      chk_out("irq", fl(R, R, R, R, W), 32'h80, 1, 0);
      tick; idle_in; #1;
      chk("post_irq.busy", 64'(busy), 64'd0);
      chk_out("post_irq", ALLW, 32'h0, 0, 1);
      // watchdog: 15 hold cycles at WDOG_W=4
      tick; hold_req = 4'b1000; hold_stage = 12'h800; #1;
      chk_out("hold4", fl(S, S, S, S, S), 32'h0, 0, 0);
      for (int i = 0; i < 14; i++) tick;
      chk("wdog14", 64'(tmo), 64'd0);
      tick;
      chk("wdog15", 64'(tmo), 64'd1);
      idle_in;
      tick; tick; tick;
      chk("wdog_sticky", 64'(tmo), 64'd1);
      timeout_clr = 1;
      tick; timeout_clr = 0; #1;
      chk("wdog_clr", 64'(tmo), 64'd0);
      // asynchronous reset mid-hold with pending and timeout set
      hold_req = 4'b0001; hold_stage = 12'h000; redirect_req = 1; redirect_pc = 32'h500; redirect_kill = 3'd1;
      tick; redirect_req = 0; #1;
      chk("rst_pre.busy", 64'(busy), 64'd1);
      for (int i = 0; i < 14; i++) tick;
      chk("rst_pre.tmo", 64'(tmo), 64'd1);
      #2; rst_n = 0; #1;
      chk_out("rst_mid", fl(S, S, S, S, S), 32'h0, 0, 0);
      chk("rst_mid.tmo", 64'(tmo), 64'd0);
      chk("rst_mid.busy", 64'(busy), 64'd0);
      tick; tick;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Parametrised pipeline flow controller for the rooth core. It generalises the single-cycle stop/refresh decoder to N stages and M hold sources, and adds sequential behaviour:
- a pending-redirect latch, so a redirect is not lost while stalled;
- a fence drain state machine;
- a stall watchdog.

It sits between the hazard sources (clint, jtag, LSU, ALU, fetch) and the per-stage pipeline registers, and drives the PC mux.

## Interface
- STAGES, 5: pipeline stages; index 0 = PC, STAGES-1 = WB.
- HOLD_SRCS, 4: number of hold request sources.
- REDIR_STAGE, 2: stage in which branch/jump redirects resolve.
- CPU_WIDTH, 32: address width.
- WDOG_W, 8: stall watchdog width. WDOG_MAX = 2^WDOG_W-1.
- Derived: SIDX_W = $clog2(STAGES).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- hold_req_i  in  HOLD_SRCS  per-source hold request.
- hold_stage_i  in  HOLD_SRCS*SIDX_W  per-source deepest stage to STOP.
- irq_req_i  in  1  interrupt assert.
- irq_addr_i  in  CPU_WIDTH  interrupt entry.
- redirect_req_i  in  1  taken branch/jump.
- redirect_pc_i  in  CPU_WIDTH  redirect target.
- redirect_kill_i  in  SIDX_W  last stage to REFRESH on redirect (≥1).
- fence_req_i  in  1  fence in REDIR_STAGE.
- fence_pc_i  in  CPU_WIDTH  fence instruction PC.
- timeout_clr_i  in  1  clears stall_timeout_o.
- flow_o  out  STAGES*FLOW_WIDTH  per-stage code; stage s at bits [s*FLOW_WIDTH +: FLOW_WIDTH].
- next_pc_o  out  CPU_WIDTH  redirect PC; valid when next_pc_vld_o.
- next_pc_vld_o  out  1  PC takes next_pc_o.
- next_pc_four_o  out  1  PC increments by 4.
- stall_timeout_o  out  1  sticky watchdog flag.
- busy_o  out  1  FSM not IDLE or pending redirect valid.

## Operation
Effective hold H = max hold_stage_i over asserted sources. A hold pattern means:
- stages 0..H STOP;
- stage H+1 REFRESH if H<STAGES-1;
- the rest WORK.

Per-cycle priority, first match wins:
1. irq_req_i:
   - stage 0 WORK, stages 1..STAGES-1 REFRESH.
   - next_pc_o=irq_addr_i, vld=1.
   - Clears pending redirect; FSM→IDLE; drain counter cleared.
2. Any hold_req_i:
   - Hold pattern; vld=0, four=0.
   - If redirect_req_i, H<REDIR_STAGE and no pending: latch redirect_pc_i/redirect_kill_i into pending.
   - If H≥REDIR_STAGE, ignore the redirect; the frozen source re-presents it.
3. Pending valid:
   - stage 0 WORK, stages 1..kill REFRESH, rest WORK.
   - vld=1 with pending PC; clear pending.
   - A same-cycle redirect_req_i is ignored.
4. FSM DRAIN:
   - stage 0 STOP, stage 1 REFRESH, rest WORK.
   - Counter decrements; at 0 → RESUME.
5. FSM RESUME:
   - all WORK; next_pc_o=latched fence_pc+4, vld=1.
   - →IDLE.
6. redirect_req_i: as step 3, using live inputs.
7. fence_req_i (IDLE only):
   - Latch fence_pc_i; counter=STAGES-2; →DRAIN.
   - This cycle: stage 0 STOP, stages 1..REDIR_STAGE REFRESH, rest WORK.
8. Otherwise all WORK, four=1.

Rules:
- vld and four are never both 1.
- A hold during DRAIN freezes the counter.
- fence_req_i outside IDLE is ignored.

Watchdog:
- Counts consecutive cycles with any hold_req_i, saturating at WDOG_MAX. Reset to 0 on a hold-free cycle.
- stall_timeout_o sets when count reaches WDOG_MAX and stays set until timeout_clr_i.
- If set and clear occur in the same cycle, set wins.

## Timing
- Flow/PC outputs are combinational from inputs plus registered state. Zero-cycle decision latency.
- Registers: FSM, drain counter, pending {vld,pc,kill}, fence_pc, watchdog, timeout flag.
- While rst_n is low: flow_o all FLOW_STOP; next_pc_o=0; vld=0, four=0; stall_timeout_o=0; busy_o=0; FSM=IDLE.
- Reset asserted mid-drain or with pending valid discards the state immediately (asynchronous).
- Fence in IDLE at cycle t with no holds:
  - t: entry.
  - t+1..t+STAGES-2: DRAIN.
  - t+STAGES-1: RESUME (vld=1).
  - t+STAGES: IDLE, four=1.
- A pending redirect is applied on the first cycle with no irq and no hold.

## Structure
- Shared package rooth_flow_pkg:
  - FLOW_WIDTH=2.
  - FLOW_WORK=2'b00, FLOW_STOP=2'b01, FLOW_REFRESH=2'b10.
  - FSM state enum {IDLE, DRAIN, RESUME}.
- Sub-module flow_hold_merge: combinational max-reduce of hold_stage_i plus hold-pattern generation.

## Test plan
- Single hold, src0 stage 3 (STAGES=5) → flow_o = STOP,STOP,STOP,STOP,REFRESH; four=0. Releases to all WORK.
- Hold src1 stage 1 and redirect_req_i, pc=0x100, kill=2, same cycle → pending latched, busy_o=1. Release → vld=1, next_pc_o=0x100, stages 1-2 REFRESH; next cycle busy_o=0.
- Hold stage 3 with redirect → no latch; after release, a re-presented redirect is applied live.
- Fence at pc 0x40, no holds → entry cycle, then 3 DRAIN cycles, then RESUME with next_pc_o=0x44. A 2-cycle hold mid-drain delays RESUME by 2.
- irq (addr 0x80) during DRAIN with pending valid → next_pc_o=0x80, stages 1-4 REFRESH; pending and FSM cleared.
- WDOG_W=4, hold held 15 cycles → stall_timeout_o rises on cycle 15 and stays set after release until timeout_clr_i. Reset mid-hold → all outputs at reset values.
